health_ctrl: RTL and testbench

- Game-logic stage directly upstream of the heart-icon overlay in the VGA draw chain.
- Tracks the player's remaining lives and drives the 3-bit per-icon enable vector and the overlay enable `en`.
- Handles hit and heal pulses, post-hit invulnerability timed in video frames, blink of the icons while invulnerable, and game-over.

---
 rtl/health_pkg.sv | 25 ++
 rtl/health_ctrl_frame_tick.sv | 19 +
 rtl/health_ctrl.sv | 168 ++++++++++++++++
 tb/tb_health_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/health_pkg.sv
// Shared types and helpers for the player-health game logic.
package health_pkg;

  localparam int unsigned MAX_LIVES = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIVE  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } health_state_t;

  // Life count to per-icon thermometer enable (bit i lights icon i).
  function automatic logic [2:0] lives_to_therm(input logic [1:0] lives);
    logic [2:0] therm;
    case (lives)
      2'd0:    therm = 3'b000;
      2'd1:    therm = 3'b001;
      2'd2:    therm = 3'b011;
      default: therm = 3'b111;
    endcase
    return therm;
  endfunction

endpackage

// File: rtl/health_ctrl_frame_tick.sv
// Frame tick generator: one-cycle pulse on each rising edge of vblnk.
module frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic tick
);

  logic r_vblnk;

  // vblnk history for edge detection
  always_ff @(posedge clk) begin
    if (rst) r_vblnk <= 1'b0;
    else     r_vblnk <= vblnk;
  end

  assign tick = vblnk & ~r_vblnk;

endmodule

// File: rtl/health_ctrl.sv
// Player health controller: lives, post-hit invulnerability with icon blink, game over.
module health_ctrl
  import health_pkg::*;
#(
  parameter int unsigned LIVES         = 3,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned BLINK_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_game,
  input  logic       hit,
  input  logic       heal,
  input  logic       vblnk,
  output logic [2:0] health_en,
  output logic       en,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam int unsigned FCW = $clog2(INVULN_FRAMES + 1);
  localparam int unsigned BCW = $clog2(BLINK_FRAMES + 1);

  localparam logic [FCW-1:0] FRAME_LOAD = FCW'(INVULN_FRAMES);
  localparam logic [FCW-1:0] FRAME_ONE  = FCW'(1);
  localparam logic [BCW-1:0] BLINK_LOAD = BCW'(BLINK_FRAMES);
  localparam logic [BCW-1:0] BLINK_ONE  = BCW'(1);
  localparam logic [1:0]     LIVES_LOAD = 2'(LIVES);
  localparam logic [1:0]     LIVES_MAX  = 2'(MAX_LIVES);

  health_state_t  r_state,     w_state;
  logic [1:0]     r_lives,     w_lives;
  logic [2:0]     r_health_en, w_health_en;
  logic           r_en,        w_en;
  logic           r_game_over, w_game_over;
  logic [FCW-1:0] r_frame_cnt, w_frame_cnt;
  logic [BCW-1:0] r_blink_cnt, w_blink_cnt;
  logic           w_tick;

  frame_tick u_frame_tick (
    .clk   (clk),
    .rst   (rst),
    .vblnk (vblnk),
    .tick  (w_tick)
  );

  // Next-state and next-output decode
  always_comb begin
    w_state     = r_state;
    w_lives     = r_lives;
    w_en        = r_en;
    w_game_over = r_game_over;
    w_frame_cnt = r_frame_cnt;
    w_blink_cnt = r_blink_cnt;

    case (r_state)
      IDLE: begin
        w_lives     = 2'd0;
        w_en        = 1'b0;
        w_game_over = 1'b0;
        w_frame_cnt = '0;
        w_blink_cnt = '0;
        if (start_game) begin
          w_state = ALIVE;
          w_lives = LIVES_LOAD;
          w_en    = 1'b1;
        end
      end

      ALIVE: begin
        if (!start_game) begin
          w_state = IDLE;
          w_lives = 2'd0;
          w_en    = 1'b0;
        end else if (hit) begin
          // hit outranks heal; a coincident tick is dropped
          if (r_lives > 2'd1) begin
            w_state     = INVULN;
            w_lives     = r_lives - 2'd1;
            w_en        = 1'b0;
            w_frame_cnt = FRAME_LOAD;
            w_blink_cnt = BLINK_LOAD;
          end else begin
            w_state     = DEAD;
            w_lives     = 2'd0;
            w_en        = 1'b1;
            w_game_over = 1'b1;
          end
        end else if (heal && (r_lives < LIVES_MAX)) begin
          w_lives = r_lives + 2'd1;
        end
      end

      INVULN: begin
        if (!start_game) begin
          w_state     = IDLE;
          w_lives     = 2'd0;
          w_en        = 1'b0;
          w_frame_cnt = '0;
          w_blink_cnt = '0;
        end else begin
          if (heal && (r_lives < LIVES_MAX)) w_lives = r_lives + 2'd1;
          if (w_tick) begin
            if (r_frame_cnt == FRAME_ONE) begin
              w_state     = ALIVE;
              w_en        = 1'b1;
              w_frame_cnt = '0;
              w_blink_cnt = '0;
            end else begin
              w_frame_cnt = r_frame_cnt - FRAME_ONE;
              // counter would hit zero on this tick: reload and flip instead
              if (r_blink_cnt == BLINK_ONE) begin
                w_blink_cnt = BLINK_LOAD;
                w_en        = ~r_en;
              end else begin
                w_blink_cnt = r_blink_cnt - BLINK_ONE;
              end
            end
          end
        end
      end

      DEAD: begin
        w_lives     = 2'd0;
        w_en        = 1'b1;
        w_game_over = 1'b1;
        if (!start_game) begin
          w_state     = IDLE;
          w_en        = 1'b0;
          w_game_over = 1'b0;
        end
      end

      default: begin
        w_state = IDLE;
      end
    endcase

    w_health_en = (w_state == DEAD) ? 3'b000 : lives_to_therm(w_lives);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lives     <= 2'd0;
      r_health_en <= 3'b000;
      r_en        <= 1'b0;
      r_game_over <= 1'b0;
      r_frame_cnt <= '0;
      r_blink_cnt <= '0;
    end else begin
      r_state     <= w_state;
      r_lives     <= w_lives;
      r_health_en <= w_health_en;
      r_en        <= w_en;
      r_game_over <= w_game_over;
      r_frame_cnt <= w_frame_cnt;
      r_blink_cnt <= w_blink_cnt;
    end
  end

  assign health_en = r_health_en;
  assign en        = r_en;
  assign lives     = r_lives;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_health_ctrl.sv
// Scoreboard bench for health_ctrl: stimulus queues expectations, a monitor checks them.
module tb_health_ctrl;

  localparam int INV = 120;
  localparam int BLK = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_game;
  logic       hit;
  logic       heal;
  logic       vblnk;
  logic [2:0] health_en;
  logic       en;
  logic [1:0] lives;
  logic       game_over;

  int n_tests = 0;
  int n_fail  = 0;

  string      q_name[$];
  logic [6:0] q_exp[$];

  always #5 clk = ~clk;

  health_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_game (start_game),
    .hit        (hit),
    .heal       (heal),
    .vblnk      (vblnk),
    .health_en  (health_en),
    .en         (en),
    .lives      (lives),
    .game_over  (game_over)
  );

  // One clock of stimulus; optionally queue the state expected after that edge.
  task automatic cyc(input logic h, input logic he, input logic v, input bit chk,
                     input string name, input logic [1:0] el, input logic [2:0] eh,
                     input logic een, input logic ego);
    hit   = h;
    heal  = he;
    vblnk = v;
    @(posedge clk);
    #1;
    hit   = 1'b0;
    heal  = 1'b0;
    vblnk = 1'b0;
    if (chk) begin
      q_name.push_back(name);
      q_exp.push_back({el, eh, een, ego});
    end
  endtask

  task automatic expect_now(input string name, input logic [1:0] el, input logic [2:0] eh,
                            input logic een, input logic ego);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, name, el, eh, een, ego);
  endtask

  // Frame ticks numbered from..to since the hit; en blinks every BLK ticks, solid at INV.
  task automatic run_ticks(input int from, input int to, input logic [1:0] el,
                           input logic [2:0] eh);
    logic e_en;
    for (int t = from; t <= to; t++) begin
      e_en = (t >= INV) ? 1'b1 : (((t / BLK) % 2) == 1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, $sformatf("tick%0d", t), el, eh, e_en, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "", 2'd0, 3'd0, 1'b0, 1'b0);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation
  initial begin
    string      n;
    logic [6:0] e;
    logic [6:0] a;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        n = q_name.pop_front();
        e = q_exp.pop_front();
        a = {lives, health_en, en, game_over};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got lives=%0d health_en=%b en=%b game_over=%b, want lives=%0d health_en=%b en=%b game_over=%b",
                   n, a[6:5], a[4:2], a[1], a[0], e[6:5], e[4:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start_game = 1'b0;
    hit        = 1'b0;
    heal       = 1'b0;
    vblnk      = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "", 2'd0, 3'd0, 1'b0, 1'b0);
    expect_now("reset", 2'd0, 3'b000, 1'b0, 1'b0);
    rst = 1'b0;
    expect_now("idle", 2'd0, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, "idle_hit_ignored", 2'd0, 3'b000, 1'b0, 1'b0);

    // Start, first hit, blink, second hit ignored, heal while invulnerable
    start_game = 1'b1;
    expect_now("start", 2'd3, 3'b111, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, "hit3", 2'd2, 3'b011, 1'b0, 1'b0);
    run_ticks(1, 10, 2'd2, 3'b011);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, "hit_in_invuln", 2'd2, 3'b011, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, "heal_in_invuln", 2'd3, 3'b111, 1'b1, 1'b0);
    run_ticks(11, INV, 2'd3, 3'b111);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, "tick_in_alive", 2'd3, 3'b111, 1'b1, 1'b0);

    // hit+heal together with two lives; heal saturates at three
    cyc(1'b1, 1'b0, 1'b0, 1'b1, "hit_to_2", 2'd2, 3'b011, 1'b0, 1'b0);
    run_ticks(1, INV, 2'd2, 3'b011);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, "hit_and_heal", 2'd1, 3'b001, 1'b0, 1'b0);
    run_ticks(1, INV, 2'd1, 3'b001);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, "heal_to_2", 2'd2, 3'b011, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, "heal_to_3", 2'd3, 3'b111, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, "heal_sat", 2'd3, 3'b111, 1'b1, 1'b0);

    // Three hits to game over, then leave
    cyc(1'b1, 1'b0, 1'b0, 1'b1, "die_hit1", 2'd2, 3'b011, 1'b0, 1'b0);
    run_ticks(1, INV, 2'd2, 3'b011);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, "die_hit2", 2'd1, 3'b001, 1'b0, 1'b0);
    run_ticks(1, INV, 2'd1, 3'b001);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, "die_hit3", 2'd0, 3'b000, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, "dead_hold", 2'd0, 3'b000, 1'b1, 1'b1);
    start_game = 1'b0;
    expect_now("dead_to_idle", 2'd0, 3'b000, 1'b0, 1'b0);

    // Abort mid-invulnerability (frame counter at 50), restart with fresh counters
    start_game = 1'b1;
    expect_now("restart1", 2'd3, 3'b111, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, "abort_hit", 2'd2, 3'b011, 1'b0, 1'b0);
    run_ticks(1, 70, 2'd2, 3'b011);
    start_game = 1'b0;
    expect_now("abort_idle", 2'd0, 3'b000, 1'b0, 1'b0);
    start_game = 1'b1;
    expect_now("restart2", 2'd3, 3'b111, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, "fresh_hit", 2'd2, 3'b011, 1'b0, 1'b0);
    run_ticks(1, 9, 2'd2, 3'b011);

    // Reset during invulnerability discards it
    rst = 1'b1;
    expect_now("rst_invuln", 2'd0, 3'b000, 1'b0, 1'b0);
    rst = 1'b0;
    expect_now("after_rst", 2'd3, 3'b111, 1'b1, 1'b0);

    for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (q_exp.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
